// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//   Walks one LED-strip frame out of a synchronous frame buffer and serves it to the serial bit
//   transmitter one bit per request, MSB first, 24-bit GRB words. While a pixel is shifting,
//   the next one is prefetched into a staging register so word boundaries need no memory wait.
//   After the last bit the latch gap is signalled and completion is reported.
//
//   Optional feature: define LED_SCHED_AUTO_REFRESH_EN to loop from the latch gap straight
//   into the next frame (continuous refresh, frame_start ignored, busy held high).
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   frame_start       request transmission of the buffer (accepted only when idle)
//   busy              high from accepted start until frame_done
//   frame_done        one-cycle pulse once the latch gap has elapsed
//   mem_rd_en         frame-buffer read strobe; mem_rd_data is valid the following cycle
//   mem_addr          frame-buffer pixel address
//   mem_rd_data       24-bit pixel word from the frame buffer
//   new_bit_rqst      transmitter consumed the current bit and wants the next
//   bit_to_transmit   current bit presented to the transmitter
//   all_bits_shifted  high when no frame bits are being served (transmitter drives latch gap)
//   latch_done        transmitter finished the latch gap
module led_frame_scheduler #(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rd_data,
  input  logic              new_bit_rqst,
  output logic              bit_to_transmit,
  output logic              all_bits_shifted,
  input  logic              latch_done
);

  localparam logic [ADDR_W:0] LastPix   = (ADDR_W + 1)'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0] PenultPix = (ADDR_W + 1)'(NUM_LEDS - 2);
  localparam logic [4:0]      TopBit    = 5'd23;

  typedef enum logic [2:0] {StIdle, StPrefetch, StLoad, StShift, StLatch} state_e;

  state_e state_q, state_d;

  logic [23:0]       shift_q, shift_d;
  logic [23:0]       stage_q, stage_d;
  logic              stage_valid_q, stage_valid_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [ADDR_W:0]   pix_q, pix_d;       // index of the pixel currently in the shift register
  logic [ADDR_W-1:0] addr_q, addr_d;     // address of the next buffer read
  logic              pf_issue_q, pf_issue_d;  // strobe a prefetch read this cycle
  logic              pf_cap_q, pf_cap_d;      // prefetch data arrives this cycle
  logic              frame_done_q, frame_done_d;

  logic is_last;
  logic word_end;

  assign is_last  = (pix_q == LastPix);
  assign word_end = (state_q == StShift) && new_bit_rqst && (bit_cnt_q == 5'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (frame_start) state_d = StPrefetch;
      StPrefetch: state_d = StLoad;
      StLoad:     state_d = StShift;
      StShift:    if (word_end && is_last) state_d = StLatch;
      StLatch: begin
        if (latch_done) begin
`ifdef LED_SCHED_AUTO_REFRESH_EN
          state_d = StPrefetch;
`else
          state_d = StIdle;
`endif
        end
      end
      default:    state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy             = (state_q != StIdle);
    all_bits_shifted = (state_q != StShift);
    mem_rd_en        = (state_q == StPrefetch) || ((state_q == StShift) && pf_issue_q);
    mem_addr         = addr_q;
    bit_to_transmit  = shift_q[23];
    frame_done       = frame_done_q;
  end

  // Datapath next-state
  always_comb begin
    shift_d       = shift_q;
    stage_d       = stage_q;
    stage_valid_d = stage_valid_q;
    bit_cnt_d     = bit_cnt_q;
    pix_d         = pix_q;
    addr_d        = addr_q;
    pf_issue_d    = pf_issue_q;
    pf_cap_d      = pf_cap_q;
    frame_done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_start) begin
          pix_d         = '0;
          addr_d        = '0;
          stage_valid_d = 1'b0;
          pf_issue_d    = 1'b0;
          pf_cap_d      = 1'b0;
        end
      end
      StLoad: begin
        shift_d    = mem_rd_data;
        bit_cnt_d  = TopBit;
        addr_d     = addr_q + 1'b1;
        pf_issue_d = !is_last;
      end
      StShift: begin
        if (pf_issue_q) begin
          pf_issue_d = 1'b0;
          pf_cap_d   = 1'b1;
        end
        if (pf_cap_q) begin
          stage_d       = mem_rd_data;
          stage_valid_d = 1'b1;
          pf_cap_d      = 1'b0;
        end
        if (new_bit_rqst) begin
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else if (!is_last) begin
            shift_d       = stage_q;
            stage_valid_d = 1'b0;
            bit_cnt_d     = TopBit;
            pix_d         = pix_q + 1'b1;
            // Only advance the address while a further pixel is still to be fetched, so the
            // address never runs past the last pixel.
            if (pix_q < PenultPix) begin
              addr_d     = addr_q + 1'b1;
              pf_issue_d = 1'b1;
            end
          end
          // On the final bit of the frame the shift register holds its last value.
        end
      end
      StLatch: begin
        if (latch_done) begin
          frame_done_d  = 1'b1;
          pix_d         = '0;
          addr_d        = '0;
          stage_valid_d = 1'b0;
          pf_issue_d    = 1'b0;
          pf_cap_d      = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      stage_q       <= '0;
      stage_valid_q <= 1'b0;
      bit_cnt_q     <= '0;
      pix_q         <= '0;
      addr_q        <= '0;
      pf_issue_q    <= 1'b0;
      pf_cap_q      <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      stage_q       <= stage_d;
      stage_valid_q <= stage_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      pix_q         <= pix_d;
      addr_q        <= addr_d;
      pf_issue_q    <= pf_issue_d;
      pf_cap_q      <= pf_cap_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // The transmitter's request spacing guarantees the staging word is ready at a word boundary.
  always @(posedge clk) begin
    if (!rst && word_end && !is_last) begin
      assert (stage_valid_q) else $error("led_frame_scheduler: staging empty at word boundary");
    end
  end

endmodule
